prbs7_tx_gen: RTL and testbench

//  32-bit/cycle PRBS7 (x^7+x^6+1) pattern transmitter, 40MHz, for GBS20 SERDES link tests on KC705.
//  TX-side partner of the PRBS7 aligner/checker: feeds serializer or loopback; RX aligns and counts errors.

---
 rtl/prbs7_tx_gen.sv | 205 ++++++++++++++++++++
 tb/tb_prbs7_tx_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs7_tx_gen.sv
// ---------------------------------------------------------------------------
// prbs7_tx_gen
//   32-bit/cycle PRBS7 (x^7 + x^6 + 1) pattern transmitter for SERDES link
//   tests. It is the TX-side partner of the PRBS7 aligner/checker. It adds a
//   programmable bit slip to exercise the RX alignment search. It can also
//   inject a single-bit error (optional, see below).
//
//   Stream definition: b[n] = b[n-7] ^ b[n-6]. The 7-bit LFSR holds the seven
//   most recent stream bits, with lfsr[0] the oldest and lfsr[6] the newest.
//   Each RUN cycle produces raw word r[i] = b[i], i = 0..31, where bit 0 is
//   the oldest bit.
//
//   Optional feature macro: PRBS_TX_ERR_INJ_EN
//     defined   : inject/err_pos flip one bit of a later valid word and
//                 inj_count counts applied flips (saturating).
//     undefined : inject/err_pos are unused and inj_count is tied to zero.
//
// Ports
//   clk         in   1   40 MHz clock
//   reset       in   1   asynchronous, active-high reset
//   start       in   1   level; sampled in IDLE, starts a run
//   stop        in   1   level; sampled in RUN, ends the run (beats inject)
//   seed        in   7   LFSR seed, sampled in LOAD (0 selects DEF_SEED)
//   slip        in   5   bit offset 0..31 of the output window
//   inject      in   1   pulse; request one flipped bit
//   err_pos     in   5   bit index flipped on injection
//   dout        out  32  transmit word; dout[0] oldest bit, dout[31] newest
//   dout_valid  out  1   dout carries PRBS data
//   word_count  out  32  valid words emitted, wraps
//   inj_count   out  16  injections applied, saturates at 16'hFFFF
// ---------------------------------------------------------------------------
module prbs7_tx_gen #(
    parameter logic [31:0] IDLE_WORD = 32'hAAAA_AAAA,
    parameter logic [6:0]  DEF_SEED  = 7'h7F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [6:0]  seed,
    input  logic [4:0]  slip,
    input  logic        inject,
    input  logic [4:0]  err_pos,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic [31:0] word_count,
    output logic [15:0] inj_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } stateType;

    stateType    state;
    logic [6:0]  lfsr;
    logic [63:0] slipBuf;
    logic        primed;      // slip buffer holds at least one raw word of this run

    logic [38:0] prbsExt;
    logic [31:0] rawWord;
    logic [6:0]  lfsrNext;
    logic [63:0] slipBufNext;
    logic [31:0] windowWord;

    // Extend the 7-bit history by 32 new bits. The result holds the history
    // in [6:0] and the new bits in [38:7].
    function automatic logic [38:0] prbsExtend(input logic [6:0] hist);
        logic [38:0] ext;
        ext      = 39'd0;
        ext[6:0] = hist;
        for (int i = 7; i < 39; i++) begin
            ext[i] = ext[i-7] ^ ext[i-6];
        end
        return ext;
    endfunction

    // Select the 32-bit window starting at bit 'offset' of the 64-bit buffer.
    function automatic logic [31:0] windowSelect(input logic [63:0] bufVal,
                                                 input logic [4:0]  offset);
        logic [63:0] shifted;
        shifted = bufVal >> offset;
        return shifted[31:0];
    endfunction

    // Next raw word, the next LFSR state and the slip window. The window is
    // taken over the buffer contents after this cycle's shift, so with slip=0
    // it gives the previous raw word unchanged.
    always_comb begin
        prbsExt     = prbsExtend(lfsr);
        rawWord     = prbsExt[38:7];
        lfsrNext    = prbsExt[38:32];
        slipBufNext = {rawWord, slipBuf[63:32]};
        windowWord  = windowSelect(slipBufNext, slip);
    end

`ifdef PRBS_TX_ERR_INJ_EN
    logic        pending;
    logic [31:0] flipMask;
    logic        applyFlip;

    // The flip lands on the next valid word. If stop arrives in the same
    // cycle, the request is dropped instead.
    always_comb begin
        flipMask  = 32'd1 << err_pos;
        applyFlip = 1'b0;
        if (state == RUN && primed && pending && !stop) begin
            applyFlip = 1'b1;
        end else begin
            applyFlip = 1'b0;
        end
    end

    // Injection request tracking and the saturating count of applied flips
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= 1'b0;
            inj_count <= 16'h0000;
        end else if (state != RUN || stop) begin
            pending <= 1'b0;
        end else if (applyFlip) begin
            pending <= 1'b0;
            if (inj_count != 16'hFFFF) begin
                inj_count <= inj_count + 16'd1;
            end else begin
                inj_count <= inj_count;
            end
        end else if (inject && !pending) begin
            pending <= 1'b1;
        end else begin
            pending <= pending;
        end
    end
`else
    logic        applyFlip;
    logic [31:0] flipMask;
    logic        unusedInjInputs;

    assign applyFlip       = 1'b0;
    assign flipMask        = 32'd0;
    assign unusedInjInputs = ^{inject, err_pos};
    assign inj_count       = 16'h0000;
`endif

    // Control FSM, LFSR, slip buffer and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lfsr       <= DEF_SEED;
            slipBuf    <= 64'd0;
            primed     <= 1'b0;
            dout       <= IDLE_WORD;
            dout_valid <= 1'b0;
            word_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    dout       <= IDLE_WORD;
                    dout_valid <= 1'b0;
                    primed     <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    // A zero seed would lock the LFSR up, so it is replaced.
                    lfsr       <= (seed == 7'h00) ? DEF_SEED : seed;
                    dout       <= IDLE_WORD;
                    dout_valid <= 1'b0;
                    primed     <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    lfsr    <= lfsrNext;
                    slipBuf <= slipBufNext;
                    primed  <= 1'b1;
                    // The first RUN cycle only primes the buffer.
                    if (primed) begin
                        dout       <= applyFlip ? (windowWord ^ flipMask) : windowWord;
                        dout_valid <= 1'b1;
                        word_count <= word_count + 32'd1;
                    end else begin
                        dout       <= IDLE_WORD;
                        dout_valid <= 1'b0;
                    end
                    if (stop) begin
                        state <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dout       <= IDLE_WORD;
                    dout_valid <= 1'b0;
                    primed     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prbs7_tx_gen.sv
// ---------------------------------------------------------------------------
// tb_prbs7_tx_gen
//   Directed bench for prbs7_tx_gen. A bit-serial PRBS7 reference and a
//   cycle-level model push the expected outputs for each edge into a queue.
//   After the edge, the expected entry is popped and compared with the DUT.
// ---------------------------------------------------------------------------
module tb_prbs7_tx_gen;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [6:0]  seed;
    logic [4:0]  slip;
    logic        inject;
    logic [4:0]  err_pos;
    logic [31:0] dout;
    logic        dout_valid;
    logic [31:0] word_count;
    logic [15:0] inj_count;

    prbs7_tx_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .seed       (seed),
        .slip       (slip),
        .inject     (inject),
        .err_pos    (err_pos),
        .dout       (dout),
        .dout_valid (dout_valid),
        .word_count (word_count),
        .inj_count  (inj_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] IDLE_W = 32'hAAAA_AAAA;
    localparam int STREAM_LEN = 8192;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [31:0] wc;
        logic [15:0] ic;
    } expT;

    expT  expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int          mState;        // 0 idle, 1 load, 2 run
    logic        mPrimed;
    int          mWordIdx;
    logic [31:0] mWordCount;
    logic [15:0] mInjCount;
    logic        mPending;
    logic        streamBits [0:STREAM_LEN-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: seed bit k is history bit b[k-7].
    task automatic genStream(input logic [6:0] s);
        logic hist [0:STREAM_LEN+6];
        for (int k = 0; k < 7; k++) hist[k] = s[k];
        for (int k = 7; k < STREAM_LEN + 7; k++) hist[k] = hist[k-7] ^ hist[k-6];
        for (int n = 0; n < STREAM_LEN; n++) streamBits[n] = hist[n+7];
    endtask

    task automatic modelReset();
        mState     = 0;
        mPrimed    = 1'b0;
        mWordIdx   = 0;
        mWordCount = 32'd0;
        mInjCount  = 16'd0;
        mPending   = 1'b0;
        expQ.delete();
    endtask

    // Push expected outputs for the coming edge, clock, then pop and compare
    task automatic cycle(input string tag);
        expT e;
        logic wasPrimed;
        e.v = 1'b0;
        e.d = IDLE_W;
        case (mState)
            0: begin
                mPending = 1'b0;
                mPrimed  = 1'b0;
                if (start) mState = 1;
            end
            1: begin
                genStream((seed == 7'h00) ? 7'h7F : seed);
                mWordIdx = 0;
                mPrimed  = 1'b0;
                mState   = 2;
            end
            default: begin
                wasPrimed = mPrimed;
                if (wasPrimed) begin
                    e.v = 1'b1;
                    for (int i = 0; i < 32; i++) e.d[i] = streamBits[32*mWordIdx + int'(slip) + i];
                    mWordIdx++;
                    mWordCount = mWordCount + 32'd1;
                end
`ifdef PRBS_TX_ERR_INJ_EN
                if (stop) begin
                    mPending = 1'b0;
                end else if (mPending && wasPrimed) begin
                    e.d[err_pos] = ~e.d[err_pos];
                    mPending = 1'b0;
                    if (mInjCount != 16'hFFFF) mInjCount = mInjCount + 16'd1;
                end else if (inject && !mPending) begin
                    mPending = 1'b1;
                end
`endif
                mPrimed = 1'b1;
                if (stop) mState = 0;
            end
        endcase
        e.wc = mWordCount;
        e.ic = mInjCount;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        chk({tag, "_valid"}, {31'd0, dout_valid}, {31'd0, e.v});
        chk({tag, "_dout"}, dout, e.d);
        chk({tag, "_wcount"}, word_count, e.wc);
        chk({tag, "_icount"}, {16'd0, inj_count}, {16'd0, e.ic});
    endtask

    task automatic runWords(input string tag, input int n);
        logic [31:0] target;
        int budget;
        target = mWordCount + n;
        budget = n + 10;
        while (mWordCount != target && budget > 0) begin
            cycle(tag);
            budget--;
        end
        chk({tag, "_budget"}, mWordCount, target);
    endtask

    task automatic checkIdleOutputs(input string tag);
        chk({tag, "_dout"}, dout, IDLE_W);
        chk({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
        chk({tag, "_wcount"}, word_count, 32'd0);
        chk({tag, "_icount"}, {16'd0, inj_count}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        seed    = 7'h7F;
        slip    = 5'd0;
        inject  = 1'b0;
        err_pos = 5'd0;
        modelReset();

        // 1: reset values
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        reset = 1'b0;
        cycle("idle");

        // 2: seed 7F, slip 0, one-cycle start; valid three edges later
        start = 1'b1;
        cycle("e0");
        start = 1'b0;
        cycle("e1");
        cycle("e2");
        chk("e2_not_valid", {31'd0, dout_valid}, 32'd0);
        cycle("e3");
        chk("e3_valid", {31'd0, dout_valid}, 32'd1);
        runWords("run7f", 199);
        chk("wc200", word_count, 32'd200);

        // 3: seed 00 must behave exactly like seed 7F
        stop = 1'b1;
        cycle("stop1");
        stop = 1'b0;
        cycle("idle1");
        chk("idle1_valid", {31'd0, dout_valid}, 32'd0);
        seed  = 7'h00;
        start = 1'b1;
        cycle("ld0");
        start = 1'b0;
        runWords("seed0", 40);

        // 4: slip 5 then 0 mid-run, plus slip 31 boundary
        stop = 1'b1;
        cycle("stop2");
        stop = 1'b0;
        seed  = 7'h15;
        slip  = 5'd5;
        start = 1'b1;
        cycle("ld1");
        start = 1'b0;
        runWords("slip5", 20);
        slip = 5'd0;
        runWords("slip0", 10);
        slip = 5'd31;
        runWords("slip31", 5);
        slip = 5'd0;

        // 5: injection, second request while pending, later at bit 31
        err_pos = 5'd3;
        inject  = 1'b1;
        cycle("inj1");
        cycle("inj1_again");
        inject = 1'b0;
        runWords("post_inj", 6);
        err_pos = 5'd31;
        inject  = 1'b1;
        cycle("inj2");
        inject = 1'b0;
        runWords("post_inj2", 3);

        // 6: stop and start together in RUN, start held -> restart from seed
        seed  = 7'h7F;
        stop  = 1'b1;
        start = 1'b1;
        cycle("stopstart");
        chk("stopstart_state_idle_next", {31'd0, dout_valid}, 32'd1);
        stop = 1'b0;
        cycle("restart_idle");
        chk("restart_valid_low", {31'd0, dout_valid}, 32'd0);
        start = 1'b0;
        runWords("restart", 12);

        // Injection in IDLE is ignored
        stop = 1'b1;
        cycle("stop3");
        stop   = 1'b0;
        inject = 1'b1;
        cycle("idle_inj");
        inject = 1'b0;
        start  = 1'b1;
        cycle("ld3");
        start = 1'b0;
        runWords("after_idle_inj", 4);

        // 1b: asynchronous reset in mid-run
        #3;
        reset = 1'b1;
        #1;
        checkIdleOutputs("async_rst");
        modelReset();
        #1;
        reset = 1'b0;
        cycle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
